// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: timed PLL reset pulse, lock wait with timeout/retry,
// stability qualification, then core reset release. LOCK_LOSS_REPLL_EN re-pulses the PLL on lock loss.
module pll_lock_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int STABLE_CYCLES       = 1024
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       core_reset,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                        : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_PLL_RST   = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_STABLE    = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [7:0]             retry_d, loss_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lk;

   always_ff @(posedge refclk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
   end

   assign lk = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_cnt;
      loss_d  = loss_cnt;
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            // lock takes priority over a coincident timeout
            if (lk) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
               if (retry_cnt != '1) retry_d = retry_cnt + 8'd1;
            end
         end
         S_STABLE: begin
            if (!lk) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lk) begin
               if (loss_cnt != '1) loss_d = loss_cnt + 8'd1;
`ifdef LOCK_LOSS_REPLL_EN
               state_d = S_PLL_RST;
`else
               state_d = S_WAIT_LOCK;
`endif
            end
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q    <= S_PLL_RST;
         cnt_q      <= '0;
         retry_cnt  <= '0;
         loss_cnt   <= '0;
         pll_rst    <= 1'b1;
         core_reset <= 1'b1;
         ready      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_cnt  <= retry_d;
         loss_cnt   <= loss_d;
         pll_rst    <= (state_d == S_PLL_RST);
         core_reset <= (state_d != S_RUN);
         ready      <= (state_d == S_RUN);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with short timing parameters
// (pulse 4, timeout 20, stable 8, 2 sync stages).
module tb_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked;
   logic       pll_rst, core_reset, ready;
   logic [1:0] state;
   logic [7:0] retry_cnt, loss_cnt;

   int checks = 0;
   int errors = 0;

   pll_lock_sequencer #(
      .SYNC_STAGES(2),
      .RST_PULSE_CYCLES(4),
      .LOCK_TIMEOUT_CYCLES(20),
      .STABLE_CYCLES(8)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .locked(locked),
      .pll_rst(pll_rst),
      .core_reset(core_reset),
      .ready(ready),
      .state(state),
      .retry_cnt(retry_cnt),
      .loss_cnt(loss_cnt)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic       rst;
      logic       locked;
      logic [1:0] st;
      logic       pr;
      logic       cr;
      logic       rd;
      logic [7:0] retry;
      logic [7:0] loss;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int n, input logic r, input logic l, input logic [1:0] st,
                               input logic pr, input logic cr, input logic rd,
                               input logic [7:0] rt, input logic [7:0] ls);
      vec_t v;
      v.rst = r; v.locked = l; v.st = st; v.pr = pr; v.cr = cr; v.rd = rd;
      v.retry = rt; v.loss = ls;
      repeat (n) vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s, input bit eq, input int budget, input string name);
      int n = 0;
      while (((state == s) != eq) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if ((state == s) != eq) begin
         errors++;
         $display("FAIL %s: state=%0d after %0d cycles, wanted %s%0d", name, state, n,
                  eq ? "" : "not ", s);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " state"}, {6'd0, state}, 8'd0);
      chk({tag, " pll_rst"}, {7'd0, pll_rst}, 8'd1);
      chk({tag, " core_reset"}, {7'd0, core_reset}, 8'd1);
      chk({tag, " ready"}, {7'd0, ready}, 8'd0);
      chk({tag, " retry_cnt"}, retry_cnt, 8'd0);
      chk({tag, " loss_cnt"}, loss_cnt, 8'd0);
   endtask

   initial begin
      int n;
      bit cr_low;

      rst    = 1'b1;
      locked = 1'b0;

      // reset, pulse of 4, lock 5 cycles into WAIT_LOCK, 2 sync + 1 + 8 to RUN
      add(3, 1, 0, 2'd0, 1, 1, 0, 0, 0);
      add(3, 0, 0, 2'd0, 1, 1, 0, 0, 0);
      add(1, 0, 0, 2'd1, 0, 1, 0, 0, 0);
      add(5, 0, 0, 2'd1, 0, 1, 0, 0, 0);
      add(2, 0, 1, 2'd1, 0, 1, 0, 0, 0);
      add(8, 0, 1, 2'd2, 0, 1, 0, 0, 0);
      add(2, 0, 1, 2'd3, 0, 0, 1, 0, 0);

      foreach (vecs[i]) begin
         rst    = vecs[i].rst;
         locked = vecs[i].locked;
         tick();
         chk($sformatf("vec%0d state", i), {6'd0, state}, {6'd0, vecs[i].st});
         chk($sformatf("vec%0d pll_rst", i), {7'd0, pll_rst}, {7'd0, vecs[i].pr});
         chk($sformatf("vec%0d core_reset", i), {7'd0, core_reset}, {7'd0, vecs[i].cr});
         chk($sformatf("vec%0d ready", i), {7'd0, ready}, {7'd0, vecs[i].rd});
         chk($sformatf("vec%0d retry_cnt", i), retry_cnt, vecs[i].retry);
         chk($sformatf("vec%0d loss_cnt", i), loss_cnt, vecs[i].loss);
      end

      // lock loss in RUN
      locked = 1'b0;
      tick();
      chk("loss e1 state", {6'd0, state}, 8'd3);
      tick();
      chk("loss e2 state", {6'd0, state}, 8'd3);
      tick();
`ifdef LOCK_LOSS_REPLL_EN
      chk("loss state", {6'd0, state}, 8'd0);
      chk("loss pll_rst", {7'd0, pll_rst}, 8'd1);
`else
      chk("loss state", {6'd0, state}, 8'd1);
      chk("loss pll_rst", {7'd0, pll_rst}, 8'd0);
`endif
      chk("loss core_reset", {7'd0, core_reset}, 8'd1);
      chk("loss ready", {7'd0, ready}, 8'd0);
      chk("loss loss_cnt", loss_cnt, 8'd1);
      chk("loss retry_cnt", retry_cnt, 8'd0);
`ifdef LOCK_LOSS_REPLL_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("repll pulse %0d", k), {7'd0, pll_rst}, 8'd1);
      end
      tick();
      chk("repll pulse end", {7'd0, pll_rst}, 8'd0);
      chk("repll wait state", {6'd0, state}, 8'd1);
`endif

      // STABLE interrupted at count 5 needs a fresh full window
      locked = 1'b1;
      wait_state(2'd2, 1'b1, 30, "reach stable");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("stable pre %0d", k), {6'd0, state}, 8'd2);
      end
      locked = 1'b0;
      tick();
      chk("stable drop e1", {6'd0, state}, 8'd2);
      tick();
      chk("stable drop e2", {6'd0, state}, 8'd2);
      tick();
      chk("stable drop to wait", {6'd0, state}, 8'd1);
      chk("stable drop core_reset", {7'd0, core_reset}, 8'd1);
      locked = 1'b1;
      wait_state(2'd2, 1'b1, 30, "re-enter stable");
      n = 0;
      while (state != 2'd3 && n < 30) begin
         tick();
         n++;
      end
      chk("full stable window", n[7:0], 8'd8);
      chk("stable loss_cnt", loss_cnt, 8'd1);
      chk("stable retry_cnt", retry_cnt, 8'd0);

      // timeouts and retry saturation
      rst    = 1'b1;
      locked = 1'b0;
      tick();
      tick();
      chk_reset_vals("rst2");
      rst    = 1'b0;
      cr_low = 1'b0;
      repeat (4) tick();
      chk("to first wait", {6'd0, state}, 8'd1);
      for (int r = 1; r <= 2; r++) begin
         repeat (19) begin
            tick();
            if (!core_reset) cr_low = 1'b1;
         end
         chk($sformatf("to%0d pre state", r), {6'd0, state}, 8'd1);
         tick();
         chk($sformatf("to%0d state", r), {6'd0, state}, 8'd0);
         chk($sformatf("to%0d retry_cnt", r), retry_cnt, r[7:0]);
         n = 1;
         while (pll_rst && n < 10) begin
            tick();
            if (pll_rst) n++;
            if (!core_reset) cr_low = 1'b1;
         end
         chk($sformatf("to%0d pulse len", r), n[7:0], 8'd4);
         chk($sformatf("to%0d back to wait", r), {6'd0, state}, 8'd1);
      end
      chk("timeouts core_reset low seen", {7'd0, cr_low}, 8'd0);
      for (int r = 3; r <= 300; r++) begin
         repeat (24) tick();
         if (r == 254) chk("retry 254", retry_cnt, 8'd254);
         if (r == 255) chk("retry 255", retry_cnt, 8'd255);
      end
      chk("retry saturated", retry_cnt, 8'd255);
      chk("retry loss_cnt", loss_cnt, 8'd0);

      // loss saturation
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      locked = 1'b1;
      wait_state(2'd3, 1'b1, 40, "first run");
      for (int k = 1; k <= 300; k++) begin
         locked = 1'b0;
         wait_state(2'd3, 1'b0, 10, "leave run");
         locked = 1'b1;
         wait_state(2'd3, 1'b1, 60, "return run");
         if (k == 255) chk("loss 255", loss_cnt, 8'd255);
      end
      chk("loss saturated", loss_cnt, 8'd255);
      chk("loss retry_cnt", retry_cnt, 8'd0);
      chk("run ready", {7'd0, ready}, 8'd1);

      // reset mid-RUN
      rst = 1'b1;
      tick();
      chk_reset_vals("midrun rst");
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controls the PLL's rst/locked interface from the controller side: drives the PLL reset and consumes its asynchronous locked output. Issues a timed PLL reset pulse, waits for lock with a timeout and retry, and qualifies lock over a stability window. Releases a synchronous core reset to downstream logic only after lock is qualified. Runs on the 50 MHz PLL reference clock, so it stays clocked while the PLL outputs are invalid.

Parameters:
SYNC_STAGES, 2, flops in the locked synchronizer (min 2)
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (min 1)
LOCK_TIMEOUT_CYCLES, 50000, cycles to wait for lock before re-pulsing pll_rst (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive locked cycles required before releasing core reset (min 1)

Ports:
refclk  in  1  clock, PLL reference clock
rst  in  1  synchronous active-high reset
locked  in  1  PLL locked, asynchronous to refclk
pll_rst  out  1  reset to the PLL rst input, active high
core_reset  out  1  synchronous active-high reset for core logic
ready  out  1  high while in RUN
state  out  2  0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN
retry_cnt  out  8  lock timeouts, saturates at 255
loss_cnt  out  8  lock losses while in RUN, saturates at 255

Behaviour:
- Single counter, width $clog2(max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES)+1). The counter clears on every state entry.
- locked is sampled through a SYNC_STAGES flop chain. The chain clears to 0 on rst. Only the last stage (lk) is used.
- While rst=1: state=PLL_RST, pll_rst=1, core_reset=1, ready=0, counter=0, retry_cnt=0, loss_cnt=0, sync chain=0. rst overrides everything, including mid-operation.
- PLL_RST:
  - pll_rst=1, core_reset=1.
  - The counter increments each cycle. When it reaches RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles after rst deasserts, counting the first post-reset edge as cycle 1.
- WAIT_LOCK:
  - pll_rst=0, core_reset=1.
  - If lk=1, go to STABLE.
  - Otherwise, if the counter reaches LOCK_TIMEOUT_CYCLES-1, increment retry_cnt (saturating) and go to PLL_RST.
  - If lk=1 rises on the timeout cycle, lock wins: go to STABLE, retry_cnt unchanged.
- STABLE:
  - core_reset=1.
  - If lk=0, go back to WAIT_LOCK with a fresh timeout; this is not counted as a retry or a loss.
  - If lk=1 and the counter reaches STABLE_CYCLES-1, go to RUN.
- RUN:
  - core_reset=0, ready=1.
  - If lk=0: increment loss_cnt (saturating), go to WAIT_LOCK. core_reset and ready register 1 and 0 on that same edge.
- Outputs are registered. The state encoding is presented directly on the state port.
- Latency, best case, from the locked rise to the core_reset fall: SYNC_STAGES + STABLE_CYCLES + 1 cycles.
- Glitches on locked shorter than one refclk period may be missed. That is acceptable; the PLL holds locked low for many cycles on a real loss.

Optional Feature:
LOCK_LOSS_REPLL_EN:
- Defined: a lock loss in RUN goes to PLL_RST instead of WAIT_LOCK, forcing a full PLL reset pulse. loss_cnt still increments; retry_cnt does not.
- Undefined: RUN to WAIT_LOCK as specified above, relying on the PLL to relock by itself.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8.
1. rst high 3 cycles then low, locked=0 -> pll_rst high exactly 4 cycles after release. state goes 0->1. core_reset=1, ready=0 throughout.
2. locked held 0 for 60 cycles after release -> pll_rst re-pulses for 4 cycles after each 20-cycle wait. retry_cnt counts 1, 2 and so on. core_reset never deasserts.
3. locked rises 5 cycles into WAIT_LOCK and stays high -> state=2 after 2 sync cycles. core_reset falls and ready rises 8 cycles later. retry_cnt=0.
4. In STABLE, drop locked for 3 cycles at count 5, then restore -> back to WAIT_LOCK, counter restarts. A full 8-cycle window is needed before RUN. loss_cnt=0.
5. In RUN, drop locked -> 2 cycles later state=1, core_reset=1, ready=0, loss_cnt=1. With LOCK_LOSS_REPLL_EN defined: state=0 and pll_rst high for 4 cycles.
6. Force 300 timeouts; separately force 300 losses -> retry_cnt and loss_cnt each saturate at 255. Assert rst mid-RUN -> all outputs return to their reset values on the next edge.
